// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: bytes enter a small FIFO through a valid/ready handshake
// and are shifted out LSB-first at CLKS_PER_BIT clocks per bit.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_8n1: CLKS_PER_BIT must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_8n1: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic push, pop, fifo_empty, baud_last;

    // Valid/ready: a byte moves on a rising edge where in_valid && in_ready.
    // in_ready depends only on the registered count, so a full FIFO stays
    // closed even on the cycle the transmitter pops.
    assign in_ready   = (count_q != CW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count_q == '0);
    assign baud_last  = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The line level is registered from the next state so tx changes on the
    // same edge as the state it belongs to.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: one instance at 16 clocks/bit, one at 2 clocks/bit, a
// serial receiver model per line, and a byte scoreboard per instance.
module tb_uart_tx_8n1;

    localparam int CPB_A  = 16;
    localparam int CPB_B  = 2;
    localparam int DEPTH  = 4;
    localparam int TMO    = 400;
    localparam int TMO_ID = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data_a = 8'd0, in_data_b = 8'd0;
    logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic       in_ready_a, in_ready_b, tx_a, tx_b, busy_a, busy_b;
    logic [2:0] fifo_count_a, fifo_count_b;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_qa[$];
    logic [7:0] exp_qb[$];

    typedef struct {
        int          n;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [19:0] exp_bits;  // line levels in time order, one per bit period
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_tx_8n1 #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a), .fifo_count(fifo_count_a)
    );

    uart_tx_8n1 #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b), .fifo_count(fifo_count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller sits just after a rising edge; returns just after the accepting edge.
    task automatic push_byte(input int which, input logic [7:0] d);
        int   n;
        logic rdy;
        n = 0;
        rdy = 1'b0;
        if (which == 0) begin in_valid_a = 1'b1; in_data_a = d; end
        else            begin in_valid_b = 1'b1; in_data_b = d; end
        forever begin
            @(negedge clk);
            rdy = (which == 0) ? in_ready_a : in_ready_b;
            @(posedge clk);
            if (rdy || n >= TMO) break;
            n++;
        end
        check("push_accepted", {31'd0, rdy}, 1);
        if (rdy) begin
            if (which == 0) exp_qa.push_back(d);
            else            exp_qb.push_back(d);
        end
        #1;
        if (which == 0) in_valid_a = 1'b0;
        else            in_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input int which);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((which == 0) ? busy_a : busy_b) && n < TMO_ID);
        check("idle_reached", {31'd0, ((which == 0) ? busy_a : busy_b)}, 0);
        @(posedge clk);
        #1;
    endtask

    // Receiver model: frames start on a low level, each bit must hold for the
    // whole bit period, then the byte is compared against the scoreboard.
    task automatic monitor(input int which);
        int         cpb, i;
        logic       active, unstable, txv, have;
        logic [9:0] bits;
        logic [7:0] exp;
        cpb = (which == 0) ? CPB_A : CPB_B;
        active = 1'b0;
        unstable = 1'b0;
        bits = '0;
        i = 0;
        forever begin
            @(negedge clk);
            txv = (which == 0) ? tx_a : tx_b;
            if (rst) begin
                active = 1'b0;
            end else begin
                if (!active && txv == 1'b0) begin
                    active = 1'b1;
                    i = 0;
                    unstable = 1'b0;
                end
                if (active) begin
                    if (i % cpb == 0) bits[i / cpb] = txv;
                    else if (txv !== bits[i / cpb]) unstable = 1'b1;
                    i++;
                    if (i == 10 * cpb) begin
                        active = 1'b0;
                        check((which == 0) ? "frame_shape_a" : "frame_shape_b",
                              {29'd0, unstable, bits[9], bits[0]}, 32'd2);
                        have = (which == 0) ? (exp_qa.size() > 0) : (exp_qb.size() > 0);
                        check("frame_expected", {31'd0, have}, 1);
                        if (have) begin
                            exp = (which == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
                            check((which == 0) ? "rx_byte_a" : "rx_byte_b", {24'd0, bits[8:1]}, {24'd0, exp});
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_vector(input vec_t v);
        logic bad;
        push_byte(0, v.d0);
        if (v.n == 2) begin
            push_byte(0, v.d1);
        end else begin
            @(negedge clk);
            check("pre_start_tx", {31'd0, tx_a}, 1);
            check("count_after_push", {29'd0, fifo_count_a}, 1);
        end
        for (int b = 0; b < 10 * v.n; b++) begin
            bad = 1'b0;
            for (int c = 0; c < CPB_A; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) check("count_at_start", {29'd0, fifo_count_a}, v.n - 1);
                if (tx_a !== v.exp_bits[b]) bad = 1'b1;
            end
            check($sformatf("line_bit%0d_of_%02h", b, v.d0), {31'd0, bad}, 0);
        end
        check("busy_last_cycle", {31'd0, busy_a}, 1);
        @(negedge clk);
        check("busy_fall", {31'd0, busy_a}, 0);
        check("idle_tx", {31'd0, tx_a}, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   idx, cyc, accept_cyc;
        logic rdy, bad;

        vecs[0] = '{1, 8'h55, 8'h00, {10'h3FF, 1'b1, 8'h55, 1'b0}};
        vecs[1] = '{2, 8'hA5, 8'h3C, {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}};
        vecs[2] = '{1, 8'h80, 8'h00, {10'h3FF, 1'b1, 8'h80, 1'b0}};
        vecs[3] = '{1, 8'h00, 8'h00, {10'h3FF, 1'b1, 8'h00, 1'b0}};
        vecs[4] = '{1, 8'hFF, 8'h00, {10'h3FF, 1'b1, 8'hFF, 1'b0}};
        vecs[5] = '{2, 8'h01, 8'hFE, {1'b1, 8'hFE, 1'b0, 1'b1, 8'h01, 1'b0}};

        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_a", {31'd0, tx_a}, 1);
        check("rst_ready_a", {31'd0, in_ready_a}, 1);
        check("rst_busy_a", {31'd0, busy_a}, 0);
        check("rst_count_a", {29'd0, fifo_count_a}, 0);
        check("rst_tx_b", {31'd0, tx_b}, 1);
        check("rst_busy_b", {31'd0, busy_b}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        for (int k = 0; k < 6; k++) begin
            run_vector(vecs[k]);
        end

        // Six bytes offered back to back into a four-deep FIFO.
        in_valid_a = 1'b1;
        in_data_a  = 8'd1;
        idx = 1;
        cyc = 0;
        accept_cyc = -1;
        while (idx <= 6 && cyc < TMO) begin
            @(negedge clk);
            rdy = in_ready_a;
            if (cyc == 5) begin
                check("full_count", {29'd0, fifo_count_a}, 4);
                check("full_ready", {31'd0, in_ready_a}, 0);
            end
            @(posedge clk);
            if (rdy) begin
                exp_qa.push_back(in_data_a);
                if (idx == 6) accept_cyc = cyc;
                idx++;
            end
            #1 in_data_a = 8'(idx);
            cyc++;
        end
        in_valid_a = 1'b0;
        check("sixth_accept_cycle", accept_cyc, 162);
        wait_idle(0);

        // Asynchronous reset in the middle of data bit 3 with two bytes queued.
        push_byte(0, 8'hFF);
        push_byte(0, 8'h11);
        push_byte(0, 8'h22);
        repeat (70) @(posedge clk);
        @(negedge clk);
        check("pre_reset_tx", {31'd0, tx_a}, 1);
        check("pre_reset_count", {29'd0, fifo_count_a}, 2);
        check("pre_reset_busy", {31'd0, busy_a}, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, tx_a}, 1);
        check("async_rst_busy", {31'd0, busy_a}, 0);
        check("async_rst_count", {29'd0, fifo_count_a}, 0);
        check("async_rst_ready", {31'd0, in_ready_a}, 1);
        exp_qa.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 30 * CPB_A; c++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad = 1'b1;
        end
        check("quiet_after_reset", {31'd0, bad}, 0);
        @(posedge clk);
        #1;

        // Push landing on the edge that ends the previous stop bit.
        push_byte(0, 8'h5A);
        repeat (10 * CPB_A) @(posedge clk);
        #1 in_valid_a = 1'b1;
        in_data_a = 8'h80;
        @(negedge clk);
        check("late_ready", {31'd0, in_ready_a}, 1);
        @(posedge clk);
        exp_qa.push_back(8'h80);
        #1 in_valid_a = 1'b0;
        @(negedge clk);
        check("late_gap_tx", {31'd0, tx_a}, 1);
        check("late_gap_busy", {31'd0, busy_a}, 1);
        check("late_gap_count", {29'd0, fifo_count_a}, 1);
        @(negedge clk);
        check("late_start_tx", {31'd0, tx_a}, 0);
        check("late_start_count", {29'd0, fifo_count_a}, 0);
        wait_idle(0);

        // Random loopback traffic on both line rates.
        fork
            begin
                for (int k = 0; k < 256; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    push_byte(0, 8'($urandom));
                end
            end
            begin
                for (int k = 0; k < 256; k++) begin
                    repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
                    push_byte(1, 8'($urandom));
                end
            end
        join
        wait_idle(0);
        wait_idle(1);
        repeat (2) @(posedge clk);
        check("drained_a", exp_qa.size(), 0);
        check("drained_b", exp_qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
